instr_loader: RTL and testbench

Byte-serial instruction loader that sits directly upstream of the CPU's instruction memory. It accepts program bytes from the 8-bit bidirectional pins and assembles them little-endian into 32-bit words. It writes each word to consecutive instruction-memory addresses and holds the CPU in reset until a complete, valid image has been loaded.

---
 rtl/instr_loader.sv | 195 +++++++++++++++++++
 tb/tb_instr_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Byte-serial instruction loader placed in front of the CPU's instruction
// memory. It takes program bytes, packs them little-endian into 32-bit words,
// writes those words to consecutive word addresses starting at 0, and holds the
// CPU in reset until a complete, error-free image has been loaded.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, one extra byte is read after the final word. It must equal
//   the mod-256 sum of all data bytes. A mismatch sets err and keeps the CPU
//   held. When undefined, there is no CHECK state and no sum register.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         asynchronous, active-high reset
//   load_start  one-cycle request to begin or restart a load
//   load_len    number of words to load (1..2^ADDR_W), sampled with load_start
//   byte_valid  byte_data holds a valid byte
//   byte_data   program byte
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction-memory write strobe
//   mem_addr    word address of the current write
//   mem_wdata   assembled 32-bit word
//   busy        load in progress (LOAD, WRITE, CHECK)
//   done        one-cycle pulse at load completion
//   err         sticky error flag, cleared by load_start
//   cpu_hold    holds the CPU in reset while high
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        S_CHECK
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ready_next;
    logic              busy_next;

    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   words_done;
    logic [ADDR_W:0]   words_done_inc;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [31:0]       word;
    logic              accept;
    logic              last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // byte_ready is a register that is high only in LOAD/CHECK, so this is a
    // handshake on registered state, not a combinational input->output path.
    assign accept         = byte_valid && byte_ready;
    assign words_done_inc = words_done + (ADDR_W+1)'(1);
    assign last_word      = (words_done_inc == len);

    // The write port is driven straight from the address and assembly
    // registers; mem_we qualifies them, so nothing extra is needed.
    assign mem_addr  = addr;
    assign mem_wdata = word;

    // Next-state decode. load_start overrides every state; in WRITE the write
    // itself is already on the registered outputs, so it still completes.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_next = state;
        ready_next = 1'b0;
        busy_next  = 1'b0;

        if (load_start) begin
            state_next = (load_len == '0) ? S_DONE : S_LOAD;
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_LOAD:  if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
`ifdef INSTR_LOADER_CHECKSUM_EN
                S_WRITE: state_next = last_word ? S_CHECK : S_LOAD;
                S_CHECK: if (accept) state_next = S_DONE;
`else
                S_WRITE: state_next = last_word ? S_DONE : S_LOAD;
`endif
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end

        // Output decode of the upcoming state, registered below so every
        // output leaves a flop.
        case (state_next)
            S_LOAD:  begin ready_next = 1'b1; busy_next = 1'b1; end
            S_WRITE: busy_next = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin ready_next = 1'b1; busy_next = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            len        <= '0;
            words_done <= '0;
            addr       <= '0;
            byte_cnt   <= 2'd0;
            word       <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state      <= state_next;
            byte_ready <= ready_next;
            busy       <= busy_next;
            mem_we     <= (state_next == S_WRITE);
            done       <= (state_next == S_DONE);

            if (load_start) begin
                if (load_len == '0) begin
                    err <= 1'b1;
                end else begin
                    // Fresh load or restart: any partial word is simply
                    // overwritten lane by lane before the next write.
                    len        <= load_len;
                    words_done <= '0;
                    addr       <= '0;
                    byte_cnt   <= 2'd0;
                    err        <= 1'b0;
                    cpu_hold   <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum        <= 8'd0;
`endif
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        if (accept) begin
                            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                            sum      <= sum + byte_data;
`endif
                        end
                    end
                    S_WRITE: begin
                        words_done <= words_done_inc;
                        // Hold the final address instead of wrapping to 0.
                        if (!last_word) addr <= addr + ADDR_W'(1);
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (accept && byte_data != sum) err <= 1'b1;
                    end
`endif
                    S_DONE:  cpu_hold <= err;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. Directed steps in one initial block;
// expected memory writes are queued as bytes are driven and popped by a
// monitor whenever mem_we is seen. Works with or without
// INSTR_LOADER_CHECKSUM_EN (the checksum byte is sent only when defined).
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         n_total  = 0;
    int         n_writes = 0;
    int         n_done   = 0;
    logic [7:0] tb_sum;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (done === 1'b1) n_done++;
            if (mem_we === 1'b1) begin
                n_writes++;
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic start_load(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        tb_sum     = 8'd0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        if (rnd) repeat ($urandom_range(2, 0)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("byte_accepted", 32'(guard < 40), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], rnd);
            tb_sum = tb_sum + w[8*i +: 8];
        end
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic finish_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(tb_sum, 1'b0);
`endif
        wait_done(2000);
    endtask

    initial begin
        int          wr0;
        int          dn0;
        logic [31:0] w;

        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // One word: 0x00500013 at address 0, CPU released
        start_load((ADDR_W+1)'(1));
        check("t1_ready_cycle1", 32'(byte_ready), 32'd1);
        check("t1_busy",         32'(busy),       32'd1);
        check("t1_hold_loading", 32'(cpu_hold),   32'd1);
        exp_q.push_back('{addr: 7'd0, data: 32'h0050_0013});
        send_word(32'h0050_0013, 1'b0);
        finish_load();
        check("t1_writes",   32'(n_writes),   32'd1);
        check("t1_err",      32'(err),        32'd0);
        check("t1_cpu_hold", 32'(cpu_hold),   32'd0);
        check("t1_busy_off", 32'(busy),       32'd0);

        // Three words with randomly gapped byte_valid
        wr0 = n_writes;
        start_load((ADDR_W+1)'(3));
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            send_word(w, 1'b1);
        end
        finish_load();
        check("t2_writes",   32'(n_writes - wr0), 32'd3);
        check("t2_q_empty",  32'(exp_q.size()),   32'd0);
        check("t2_cpu_hold", 32'(cpu_hold),       32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Correct checksum releases the CPU
        start_load((ADDR_W+1)'(1));
        exp_q.push_back('{addr: 7'd0, data: 32'h0403_0201});
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h0A, 1'b0);
        wait_done(20);
        check("t3_good_err",  32'(err),      32'd0);
        check("t3_good_hold", 32'(cpu_hold), 32'd0);

        // Wrong checksum keeps the CPU held
        start_load((ADDR_W+1)'(1));
        exp_q.push_back('{addr: 7'd0, data: 32'h0403_0201});
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h0B, 1'b0);
        wait_done(20);
        check("t3_bad_err",  32'(err),      32'd1);
        check("t3_bad_hold", 32'(cpu_hold), 32'd1);
`endif

        // load_len = 0: immediate DONE with error, no writes
        wr0 = n_writes;
        start_load('0);
        check("t4_done_next", 32'(done),       32'd1);
        check("t4_err",       32'(err),        32'd1);
        check("t4_no_ready",  32'(byte_ready), 32'd0);
        wait_done(5);
        check("t4_err_sticky", 32'(err),          32'd1);
        check("t4_cpu_hold",   32'(cpu_hold),     32'd1);
        check("t4_no_writes",  32'(n_writes - wr0), 32'd0);

        // Restart after two bytes of the second word
        wr0 = n_writes;
        start_load((ADDR_W+1)'(2));
        exp_q.push_back('{addr: 7'd0, data: 32'hA1B2_C3D4});
        send_word(32'hA1B2_C3D4, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        start_load((ADDR_W+1)'(1));
        check("t5_err_cleared", 32'(err), 32'd0);
        exp_q.push_back('{addr: 7'd0, data: 32'h1122_3344});
        send_word(32'h1122_3344, 1'b0);
        finish_load();
        check("t5_writes",   32'(n_writes - wr0), 32'd2);
        check("t5_err",      32'(err),            32'd0);
        check("t5_cpu_hold", 32'(cpu_hold),       32'd0);

        // Reset in the middle of the second word
        wr0 = n_writes;
        start_load((ADDR_W+1)'(2));
        exp_q.push_back('{addr: 7'd0, data: 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h5A, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h6B;
        rst = 1'b1;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_writes",   32'(n_writes - wr0), 32'd1);
        check("t6_q_empty",  32'(exp_q.size()),   32'd0);
        check("t6_idle",     32'(busy),           32'd0);
        check("t6_cpu_hold", 32'(cpu_hold),       32'd1);

        // Full capacity: 128 words, last at address 127
        wr0 = n_writes;
        dn0 = n_done;
        start_load((ADDR_W+1)'(128));
        for (int i = 0; i < 128; i++) begin
            w = {8'(i), ~8'(i), 8'h5A, 8'(i * 3)};
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            send_word(w, 1'b0);
        end
        finish_load();
        repeat (5) @(negedge clk);
        check("t7_writes",   32'(n_writes - wr0), 32'd128);
        check("t7_done_one", 32'(n_done - dn0),   32'd1);
        check("t7_q_empty",  32'(exp_q.size()),   32'd0);
        check("t7_err",      32'(err),            32'd0);
        check("t7_cpu_hold", 32'(cpu_hold),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
